l2_snoop_nexus: RTL and testbench

- Downstream partner of the L1 cache's snooper interface; models the shared L2/main-memory side of the miss path.
- Accepts line-fill reads (snooper_read_valid) and dirty-line evictions (eviction_wren) from one L1.
- Evictions sit in a small write-back buffer, which drains into a line-wide backing array.
- Each read is answered with a 128-bit line a fixed LATENCY later on updated_cacheline/cacheline_update_valid; data still in the write-back buffer is forwarded to the read.

---
 rtl/l2_snoop_nexus.sv | 180 ++++++++++++++++++
 tb/tb_l2_snoop_nexus.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_snoop_nexus.sv
// l2_snoop_nexus: shared L2 / main-memory side of an L1 miss path.
// Line-fill reads are answered a fixed LATENCY after the request; dirty-line
// evictions queue in a small write-back FIFO that drains into a line-wide
// array. Buffered (and same-cycle) eviction data is forwarded to a read so a
// response never returns a stale array copy.
module l2_snoop_nexus #(
  parameter int LATENCY  = 4,  // 1..15
  parameter int IDX_W    = 8,
  parameter int WB_DEPTH = 2   // 1..4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  snooper_addr,
  input  logic         snooper_read_valid,
  input  logic         eviction_wren,
  input  logic [127:0] evictable_cacheline,
  input  logic         update_stall,
  output logic [127:0] updated_cacheline,
  output logic         cacheline_update_valid,
  output logic         nexus_busy,
  output logic [2:0]   wb_count,
  output logic         wb_overflow
);

  localparam int         LINES    = 1 << IDX_W;
  localparam logic [2:0] DEPTH_C  = 3'(WB_DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef logic [27:0]  tag_t;
  typedef logic [127:0] line_t;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  tag_t       rd_tag_q, rd_tag_d;
  line_t      resp_q, resp_d;
  logic       ovf_q, ovf_d;
  logic [2:0] wb_cnt_q, wb_cnt_d;
  tag_t       wb_tag_q  [WB_DEPTH];
  tag_t       wb_tag_d  [WB_DEPTH];
  line_t      wb_data_q [WB_DEPTH];
  line_t      wb_data_d [WB_DEPTH];
  line_t      mem_q     [LINES];

  tag_t       req_tag;
  logic       lookup;
  tag_t       lookup_tag;
  line_t      lookup_data;
  logic       pop;
  logic       push_ok;
  logic [2:0] slot;
  logic       unused_addr_bits;

  assign req_tag          = snooper_addr[31:4];
  assign unused_addr_bits = ^snooper_addr[3:0];

  // Identify the single lookup cycle of a read and the tag it resolves.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    lookup     = 1'b0;
    lookup_tag = rd_tag_q;
    if (LATENCY == 1) begin
      if (state_q == S_IDLE && snooper_read_valid) begin
        lookup     = 1'b1;
        lookup_tag = req_tag;
      end
    end else if (state_q == S_WAIT && cnt_q == 4'd1) begin
      // The countdown reaches zero in this cycle.
      lookup = 1'b1;
    end
  end

  // Resolve the line: same-cycle eviction, then newest buffered copy, then array.
  always_comb begin
    lookup_data = mem_q[lookup_tag[IDX_W-1:0]];
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (wb_cnt_q > 3'(i) && wb_tag_q[i] == lookup_tag) lookup_data = wb_data_q[i];
    end
    if (eviction_wren && req_tag == lookup_tag) lookup_data = evictable_cacheline;
  end

  // Read FSM next state: accept in IDLE, count in WAIT, hold under stall in RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_tag_d = rd_tag_q;
    resp_d   = resp_q;
    unique case (state_q)
      S_IDLE: begin
        if (snooper_read_valid) begin
          rd_tag_d = req_tag;
          if (lookup) begin
            resp_d  = lookup_data;
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (lookup) begin
          resp_d  = lookup_data;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (!update_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write-back FIFO: slot 0 is oldest; drain every cycle except the lookup cycle.
  always_comb begin
    wb_tag_d  = wb_tag_q;
    wb_data_d = wb_data_q;
    ovf_d     = ovf_q;
    pop       = (wb_cnt_q != 3'd0) && !lookup;
    slot      = pop ? (wb_cnt_q - 3'd1) : wb_cnt_q;
    push_ok   = eviction_wren && (slot < DEPTH_C);
    if (eviction_wren && !push_ok) ovf_d = 1'b1;
    if (pop) begin
      for (int i = 0; i < WB_DEPTH - 1; i++) begin
        wb_tag_d[i]  = wb_tag_q[i+1];
        wb_data_d[i] = wb_data_q[i+1];
      end
    end
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (push_ok && slot == 3'(i)) begin
        wb_tag_d[i]  = req_tag;
        wb_data_d[i] = evictable_cacheline;
      end
    end
    wb_cnt_d = slot + {2'b00, push_ok};
  end

  // Control state with synchronous reset; reset beats every other action.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_tag_q <= '0;
      resp_q   <= '0;
      wb_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_tag_q <= rd_tag_d;
      resp_q   <= resp_d;
      wb_cnt_q <= wb_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Buffer payload; validity is carried entirely by wb_cnt_q.
  always_ff @(posedge clk) begin
    wb_tag_q  <= wb_tag_d;
    wb_data_q <= wb_data_d;
  end

  // Single-port line array written by the drain; a reset cycle discards the drain.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; clearing them would need a port per
    // line, and their contents must survive a reset anyway.
    if (!reset && pop) mem_q[wb_tag_q[0][IDX_W-1:0]] <= wb_data_q[0];
  end

  assign updated_cacheline      = resp_q;
  assign cacheline_update_valid = (state_q == S_RESP);
  assign nexus_busy             = (state_q != S_IDLE);
  assign wb_count               = wb_cnt_q;
  assign wb_overflow            = ovf_q;

endmodule

// File: tb/tb_l2_snoop_nexus.sv
// Testbench for l2_snoop_nexus: directed vector table, hand sequences for the
// overflow and reset-abort corners, then random traffic against a
// transaction-level reference model built from queues and a due-cycle.
module tb_l2_snoop_nexus;

  localparam int LAT   = 4;
  localparam int DEPTH = 2;

  localparam logic [127:0] LA = {4{32'hAAAA_AAAA}};
  localparam logic [127:0] D0 = 128'hD0D0_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2 = 128'hDEAD_BEEF_0000_0002_CAFE_F00D_0000_0002;
  localparam logic [127:0] D3 = 128'h3333_0000_3333_0000_3333_0000_3333_0003;
  localparam logic [127:0] E1 = 128'hE1E1_E1E1_0000_0000_1111_1111_E1E1_E1E1;
  localparam logic [127:0] E2 = 128'hE2E2_E2E2_2222_2222_0000_0000_E2E2_E2E2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (WB_DEPTH = 2)
  logic         reset, rd, ev, stall;
  logic [31:0]  addr;
  logic [127:0] line;
  logic [127:0] o_line;
  logic         o_valid, o_busy, o_ovf;
  logic [2:0]   o_cnt;

  // Second DUT (WB_DEPTH = 1) for the overflow corner
  logic         r1, e1, s1;
  logic [31:0]  a1;
  logic [127:0] l1;
  logic [127:0] o1_line;
  logic         o1_valid, o1_busy, o1_ovf;
  logic [2:0]   o1_cnt;

  l2_snoop_nexus #(.LATENCY(LAT), .IDX_W(8), .WB_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .snooper_addr(addr), .snooper_read_valid(rd),
    .eviction_wren(ev), .evictable_cacheline(line), .update_stall(stall),
    .updated_cacheline(o_line), .cacheline_update_valid(o_valid),
    .nexus_busy(o_busy), .wb_count(o_cnt), .wb_overflow(o_ovf)
  );

  l2_snoop_nexus #(.LATENCY(LAT), .IDX_W(8), .WB_DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .snooper_addr(a1), .snooper_read_valid(r1),
    .eviction_wren(e1), .evictable_cacheline(l1), .update_stall(s1),
    .updated_cacheline(o1_line), .cacheline_update_valid(o1_valid),
    .nexus_busy(o1_busy), .wb_count(o1_cnt), .wb_overflow(o1_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [27:0]  tag;
    logic [127:0] data;
  } wb_t;

  logic [127:0] m_mem [256];
  wb_t          m_q [$];
  bit           m_pend, m_valid, m_ovf;
  logic [27:0]  m_tag;
  logic [127:0] m_data;
  int           m_look_cyc;
  int           cyc = 0;

  // One clock of the specification's rules, applied to the current inputs.
  task automatic model_step();
    bit           look;
    logic [127:0] v;
    wb_t          w;
    look = 1'b0;
    v    = '0;
    if (reset) begin
      m_q.delete();
      m_pend  = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
      m_ovf   = 1'b0;
    end else begin
      if (!m_pend && !m_valid && rd) begin
        m_pend     = 1'b1;
        m_tag      = addr[31:4];
        m_look_cyc = cyc + LAT - 1;
      end
      look = m_pend && (cyc == m_look_cyc);
      if (look) begin
        v = m_mem[m_tag[7:0]];
        foreach (m_q[i]) if (m_q[i].tag == m_tag) v = m_q[i].data;
        if (ev && addr[31:4] == m_tag) v = line;
      end
      if (m_valid && !stall) m_valid = 1'b0;
      if (look) begin
        m_valid = 1'b1;
        m_data  = v;
        m_pend  = 1'b0;
      end
      if (m_q.size() > 0 && !look) begin
        w = m_q.pop_front();
        m_mem[w.tag[7:0]] = w.data;
      end
      if (ev) begin
        if (m_q.size() < DEPTH) begin
          w.tag  = addr[31:4];
          w.data = line;
          m_q.push_back(w);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  // Advance one clock and compare the main DUT against the model.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("m_valid", 128'(o_valid), 128'(m_valid));
    check("m_busy", 128'(o_busy), 128'(m_pend || m_valid));
    check("m_wb_count", 128'(o_cnt), 128'(m_q.size()));
    check("m_overflow", 128'(o_ovf), 128'(m_ovf));
    check("m_line", o_line, m_data);
  endtask

  task automatic idle_inputs();
    rd = 1'b0; ev = 1'b0; stall = 1'b0; addr = '0; line = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         rd, ev, stall;
    logic [31:0]  addr;
    logic [127:0] line;
    logic         e_valid, e_busy;
    logic [2:0]   e_cnt;
    logic [127:0] e_data;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic r, input logic e, input logic s, input logic [31:0] a,
                     input logic [127:0] l, input logic xv, input logic xb,
                     input logic [2:0] xc, input logic [127:0] xd);
    vec_t t;
    t.rd = r; t.ev = e; t.stall = s; t.addr = a; t.line = l;
    t.e_valid = xv; t.e_busy = xb; t.e_cnt = xc; t.e_data = xd;
    vecs.push_back(t);
  endtask

  task automatic add_idle(input logic xv, input logic xb, input logic [2:0] xc,
                          input logic [127:0] xd);
    add(1'b0, 1'b0, 1'b0, 32'h0, '0, xv, xb, xc, xd);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h0;
    a[20]  = 1'($urandom_range(0, 1));
    a[5:4] = 2'($urandom_range(0, 3));
    a[3:0] = 4'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;
    idle_inputs();
    r1 = 1'b0; e1 = 1'b0; s1 = 1'b0; a1 = '0; l1 = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", 128'(o_valid), 128'(1'b0));
    check("rst_busy", 128'(o_busy), 128'(1'b0));
    check("rst_line", o_line, '0);
    check("rst_wb_count", 128'(o_cnt), 128'(3'd0));
    check("rst_overflow", 128'(o_ovf), 128'(1'b0));

    // Preload line 0x12 and read it: valid exactly LATENCY cycles later.
    add(1'b0, 1'b1, 1'b0, 32'h120, LA, 1'b0, 1'b0, 3'd1, '0);
    add_idle(1'b0, 1'b0, 3'd0, '0);
    add(1'b1, 1'b0, 1'b0, 32'h120, '0, 1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b1, 1'b1, 3'd0, LA);
    add_idle(1'b0, 1'b0, 3'd0, '0);
    // Eviction then read one cycle later.
    add(1'b0, 1'b1, 1'b0, 32'h340, D1, 1'b0, 1'b0, 3'd1, '0);
    add(1'b1, 1'b0, 1'b0, 32'h340, '0, 1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b1, 1'b1, 3'd0, D1);
    add_idle(1'b0, 1'b0, 3'd0, '0);
    // Entry still buffered at lookup: forwarded from the FIFO.
    add(1'b1, 1'b0, 1'b0, 32'h560, '0, 1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b0, 1'b1, 3'd0, '0);
    add(1'b0, 1'b1, 1'b0, 32'h560, D3, 1'b0, 1'b1, 3'd1, '0);
    add_idle(1'b1, 1'b1, 3'd1, D3);
    add_idle(1'b0, 1'b0, 3'd0, '0);
    // Eviction in the lookup cycle beats the older array value.
    add(1'b0, 1'b1, 1'b0, 32'h780, D0, 1'b0, 1'b0, 3'd1, '0);
    add(1'b1, 1'b0, 1'b0, 32'h780, '0, 1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b0, 1'b1, 3'd0, '0);
    add(1'b0, 1'b1, 1'b0, 32'h780, D2, 1'b1, 1'b1, 3'd1, D2);
    add_idle(1'b0, 1'b0, 3'd0, '0);
    // Stall held 3 cycles; a read during RESP is ignored.
    add(1'b1, 1'b0, 1'b0, 32'h120, '0, 1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b0, 1'b1, 3'd0, '0);
    add_idle(1'b1, 1'b1, 3'd0, LA);
    add(1'b0, 1'b0, 1'b1, 32'h0, '0, 1'b1, 1'b1, 3'd0, LA);
    add(1'b0, 1'b0, 1'b1, 32'h0, '0, 1'b1, 1'b1, 3'd0, LA);
    add(1'b1, 1'b0, 1'b1, 32'h340, '0, 1'b1, 1'b1, 3'd0, LA);
    add_idle(1'b0, 1'b0, 3'd0, '0);
    add_idle(1'b0, 1'b0, 3'd0, '0);

    foreach (vecs[i]) begin
      rd = vecs[i].rd; ev = vecs[i].ev; stall = vecs[i].stall;
      addr = vecs[i].addr; line = vecs[i].line;
      tick();
      check($sformatf("vec%0d_valid", i), 128'(o_valid), 128'(vecs[i].e_valid));
      check($sformatf("vec%0d_busy", i), 128'(o_busy), 128'(vecs[i].e_busy));
      check($sformatf("vec%0d_wb_count", i), 128'(o_cnt), 128'(vecs[i].e_cnt));
      if (vecs[i].e_valid) check($sformatf("vec%0d_line", i), o_line, vecs[i].e_data);
    end
    idle_inputs();
    check("array_34", dut.mem_q[8'h34], D1);
    check("array_56", dut.mem_q[8'h56], D3);
    check("array_78", dut.mem_q[8'h78], D2);

    // WB_DEPTH=1: buffer full at the lookup cycle plus a new eviction -> dropped.
    r1 = 1'b1; a1 = 32'h100;
    tick();
    r1 = 1'b0;
    tick();
    e1 = 1'b1; a1 = 32'h200; l1 = E1;
    tick();
    check("ovf_pre_count", 128'(o1_cnt), 128'(3'd1));
    check("ovf_pre_flag", 128'(o1_ovf), 128'(1'b0));
    a1 = 32'h300; l1 = E2;
    tick();
    check("ovf_resp_valid", 128'(o1_valid), 128'(1'b1));
    check("ovf_resp_line", o1_line, '0);
    check("ovf_flag", 128'(o1_ovf), 128'(1'b1));
    check("ovf_count", 128'(o1_cnt), 128'(3'd1));
    e1 = 1'b0; a1 = '0; l1 = '0;
    tick();
    check("ovf_consumed", 128'(o1_valid), 128'(1'b0));
    check("ovf_drained", 128'(o1_cnt), 128'(3'd0));
    for (int k = 0; k < 5; k++) tick();
    check("ovf_sticky", 128'(o1_ovf), 128'(1'b1));
    check("ovf_kept_line", dut1.mem_q[8'h20], E1);
    check("ovf_dropped_line", dut1.mem_q[8'h30], '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ovf_cleared", 128'(o1_ovf), 128'(1'b0));

    // Reset while in WAIT with two buffered entries aborts everything.
    rd = 1'b1; addr = 32'h120;
    tick();
    rd = 1'b0;
    tick();
    ev = 1'b1; addr = 32'hC00; line = D0;
    tick();
    addr = 32'hC10; line = D1;
    tick();
    addr = 32'hC20; line = D2;
    tick();
    rd = 1'b1; addr = 32'hC30; line = D3;
    tick();
    idle_inputs();
    check("abort_pre_busy", 128'(o_busy), 128'(1'b1));
    check("abort_pre_count", 128'(o_cnt), 128'(3'd2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_valid", 128'(o_valid), 128'(1'b0));
    check("abort_busy", 128'(o_busy), 128'(1'b0));
    check("abort_count", 128'(o_cnt), 128'(3'd0));
    check("abort_line", o_line, '0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("abort_no_valid%0d", k), 128'(o_valid), 128'(1'b0));
    end
    check("abort_drained_c1", dut.mem_q[8'hC1], D1);
    check("abort_discarded_c2", dut.mem_q[8'hC2], '0);
    check("abort_discarded_c3", dut.mem_q[8'hC3], '0);

    // Random traffic against the reference model (aliasing via addr[20]).
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      rd    = ($urandom_range(0, 2) == 0);
      ev    = ($urandom_range(0, 2) == 0);
      stall = ($urandom_range(0, 2) == 0);
      addr  = rand_addr();
      line  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    reset = 1'b0;
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
